// File: rtl/aesl_deadlock_reporter_if.sv
// aesl_deadlock_reporter_if: report record bus from the deadlock reporter to the logger
// Fields: report_valid/report_ready handshake, report_cycle timestamp, and the captured
// report_idle, report_chan_block and report_axis_block vectors. The master drives the record.
`timescale 1ns/1ps
interface aesl_deadlock_reporter_if #(
  parameter int NUM_PROC = 4,
  parameter int AXIS_W = 12,
  parameter int CNT_W = 32
);
  logic                report_valid;
  logic                report_ready;
  logic [CNT_W-1:0]    report_cycle;
  logic [NUM_PROC-1:0] report_idle;
  logic [NUM_PROC-1:0] report_chan_block;
  logic [AXIS_W-1:0]   report_axis_block;
  modport master(output report_valid, report_cycle, report_idle, report_chan_block, report_axis_block,
                 input report_ready);
  modport slave(input report_valid, report_cycle, report_idle, report_chan_block, report_axis_block,
                output report_ready);
endinterface

// File: rtl/aesl_deadlock_reporter.sv
// aesl_deadlock_reporter: confirms a sustained monitor block, snapshots state and reports it once
// Ports: clock, reset (async, active-low); enable gates detection; clear releases HALT;
// block_in is the top monitor block; inst_idle_sigs, inst_block_sigs, axis_block_sigs are captured
// at confirmation; rpt carries the record over valid/ready; deadlock is sticky until clear;
// event_count counts accepted reports, saturating at 255.
`timescale 1ns/1ps
module aesl_deadlock_reporter #(
  parameter int NUM_PROC = 4,
  parameter int AXIS_W = 12,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic                block_in,
  input  logic [NUM_PROC-1:0] inst_idle_sigs,
  input  logic [NUM_PROC-1:0] inst_block_sigs,
  input  logic [AXIS_W-1:0]   axis_block_sigs,
  aesl_deadlock_reporter_if.master rpt,
  output logic                deadlock,
  output logic [7:0]          event_count
);
  localparam logic [1:0] MONITOR = 2'd0, ARMED = 2'd1, REPORT = 2'd2, HALT = 2'd3;
  localparam logic [15:0] LAST = 16'(HOLD_CYCLES - 1);
  logic [1:0] state;
  logic [15:0] run;
  logic [CNT_W-1:0] cycle;
  logic confirm;
  // A single-cycle hold confirms straight out of MONITOR; otherwise the run must reach HOLD_CYCLES-1 in ARMED.
  assign confirm = enable & block_in &
                   ((state == MONITOR && HOLD_CYCLES == 1) || (state == ARMED && run == LAST));
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= MONITOR;
      run <= '0;
      cycle <= '0;
      deadlock <= 1'b0;
      event_count <= '0;
      rpt.report_valid <= 1'b0;
      rpt.report_cycle <= '0;
      rpt.report_idle <= '0;
      rpt.report_chan_block <= '0;
      rpt.report_axis_block <= '0;
    end else begin
      cycle <= &cycle ? cycle : cycle + 1'b1;
      if (confirm) begin
        rpt.report_valid <= 1'b1;
        rpt.report_cycle <= cycle;
        rpt.report_idle <= inst_idle_sigs;
        rpt.report_chan_block <= inst_block_sigs;
        rpt.report_axis_block <= axis_block_sigs;
        deadlock <= 1'b1;
        run <= '0;
        state <= REPORT;
      end else
        case (state)
          MONITOR: if (enable & block_in) begin
            run <= 16'd1;
            state <= ARMED;
          end
          ARMED: if (enable & block_in) run <= run + 1'b1;
          else begin
            run <= '0;
            state <= MONITOR;
          end
          REPORT: if (rpt.report_ready) begin
            rpt.report_valid <= 1'b0;
            event_count <= event_count + {7'd0, ~&event_count};
            state <= HALT;
          end
          HALT: if (clear) begin
            deadlock <= 1'b0;
            run <= '0;
            state <= MONITOR;
          end
        endcase
    end
endmodule
